// File: rtl/seg_mux_ctrl_if.sv
// Digit inputs and display drive outputs of the two-digit seven-segment scanner.
interface seg_mux_ctrl_if;
    logic       en;
    logic [3:0] s0;
    logic [3:0] s1;
    logic [3:0] digit_sel;
    logic [1:0] switch;
    logic       frame_tick;

    modport master (
        output en, s0, s1,
        input  digit_sel, switch, frame_tick
    );

    modport slave (
        input  en, s0, s1,
        output digit_sel, switch, frame_tick
    );
endinterface

// File: rtl/seg_mux_ctrl.sv
// Two-digit time-multiplexed seven-segment scan controller with registered outputs.
// Define SEG_MUX_BLANK_EN to insert dark BLANK0/BLANK1 gaps between digits.
module seg_mux_ctrl #(
    parameter int unsigned DWELL_CYCLES = 10_000,
    parameter int unsigned BLANK_CYCLES = 100
) (
    input logic          int_osc,
    input logic          reset,
    seg_mux_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        SHOW0,
        BLANK0,
        SHOW1,
        BLANK1
    } state_t;

    localparam logic [23:0] DWELL_LAST = 24'(DWELL_CYCLES - 1);
    localparam logic [23:0] BLANK_LAST = 24'(BLANK_CYCLES - 1);

`ifdef SEG_MUX_BLANK_EN
    localparam state_t      LAST_STATE = BLANK1;
    localparam logic [23:0] LAST_CNT   = BLANK_LAST;
`else
    localparam state_t      LAST_STATE = SHOW1;
    localparam logic [23:0] LAST_CNT   = DWELL_LAST;
`endif

    state_t      state;
    state_t      state_nx;
    logic [23:0] cnt;
    logic [23:0] cnt_nx;
    logic [3:0]  cap0;
    logic [3:0]  cap1;
    logic        enter0;
    logic        enter1;

    logic [3:0]  digit_sel_q;
    logic [1:0]  switch_q;
    logic        frame_tick_q;
    logic [3:0]  digit_sel_nx;
    logic [1:0]  switch_nx;
    logic        frame_tick_nx;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 24'd1;
        if (!bus.en) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = SHOW0;
                    cnt_nx   = '0;
                end
                SHOW0: begin
                    if (cnt == DWELL_LAST) begin
`ifdef SEG_MUX_BLANK_EN
                        state_nx = BLANK0;
`else
                        state_nx = SHOW1;
`endif
                        cnt_nx   = '0;
                    end
                end
                BLANK0: begin
                    if (cnt == BLANK_LAST) begin
                        state_nx = SHOW1;
                        cnt_nx   = '0;
                    end
                end
                SHOW1: begin
                    if (cnt == DWELL_LAST) begin
`ifdef SEG_MUX_BLANK_EN
                        state_nx = BLANK1;
`else
                        state_nx = SHOW0;
`endif
                        cnt_nx   = '0;
                    end
                end
                BLANK1: begin
                    if (cnt == BLANK_LAST) begin
                        state_nx = SHOW0;
                        cnt_nx   = '0;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so the registers already hold
    // the new digit on the very edge that enters it.
    always_comb begin
        enter0        = (state_nx == SHOW0) && (state != SHOW0);
        enter1        = (state_nx == SHOW1) && (state != SHOW1);
        switch_nx     = 2'b00;
        digit_sel_nx  = 4'h0;
        case (state_nx)
            SHOW0: begin
                switch_nx    = 2'b01;
                digit_sel_nx = enter0 ? bus.s0 : cap0;
            end
            SHOW1: begin
                switch_nx    = 2'b10;
                digit_sel_nx = enter1 ? bus.s1 : cap1;
            end
            default: begin
                switch_nx    = 2'b00;
                digit_sel_nx = 4'h0;
            end
        endcase
        frame_tick_nx = (state_nx == LAST_STATE) && (cnt_nx == LAST_CNT);
    end

    always_ff @(posedge int_osc or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            cap0         <= '0;
            cap1         <= '0;
            switch_q     <= '0;
            digit_sel_q  <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            if (enter0) cap0 <= bus.s0;
            if (enter1) cap1 <= bus.s1;
            switch_q     <= switch_nx;
            digit_sel_q  <= digit_sel_nx;
            frame_tick_q <= frame_tick_nx;
        end
    end

    assign bus.switch     = switch_q;
    assign bus.digit_sel  = digit_sel_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_mux_ctrl.sv
// Bench for seg_mux_ctrl: three parameterisations against a frame-position model.
module tb_seg_mux_ctrl;

    localparam int unsigned DW [3] = '{4, 1, 3};
    localparam int unsigned BW [3] = '{2, 1, 5};

`ifdef SEG_MUX_BLANK_EN
    localparam logic [23:0] EXP_A = 24'h550AA0;
    localparam logic [23:0] EXP_B = 24'h484848;
    localparam logic [23:0] EXP_C = 24'h5400A8;
    localparam int TK_A = 2, TK_B = 6, TK_C = 1;
    localparam int LA = 12, S1A = 6;
`else
    localparam logic [23:0] EXP_A = 24'h55AA55;
    localparam logic [23:0] EXP_B = 24'h666666;
    localparam logic [23:0] EXP_C = 24'h56A56A;
    localparam int TK_A = 3, TK_B = 12, TK_C = 4;
    localparam int LA = 8, S1A = 4;
`endif

    logic       int_osc;
    logic       reset;
    logic       en;
    logic [3:0] s0;
    logic [3:0] s1;

    logic [1:0] sw [3];
    logic [3:0] ds [3];
    logic       ft [3];

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    seg_mux_ctrl_if ifa ();
    seg_mux_ctrl_if ifb ();
    seg_mux_ctrl_if ifc ();

    assign ifa.en = en;  assign ifa.s0 = s0;  assign ifa.s1 = s1;
    assign ifb.en = en;  assign ifb.s0 = s0;  assign ifb.s1 = s1;
    assign ifc.en = en;  assign ifc.s0 = s0;  assign ifc.s1 = s1;
    assign sw[0] = ifa.switch;  assign ds[0] = ifa.digit_sel;  assign ft[0] = ifa.frame_tick;
    assign sw[1] = ifb.switch;  assign ds[1] = ifb.digit_sel;  assign ft[1] = ifb.frame_tick;
    assign sw[2] = ifc.switch;  assign ds[2] = ifc.digit_sel;  assign ft[2] = ifc.frame_tick;

    seg_mux_ctrl #(.DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut_a (
        .int_osc(int_osc), .reset(reset), .bus(ifa)
    );
    seg_mux_ctrl #(.DWELL_CYCLES(1), .BLANK_CYCLES(1)) dut_b (
        .int_osc(int_osc), .reset(reset), .bus(ifb)
    );
    seg_mux_ctrl #(.DWELL_CYCLES(3), .BLANK_CYCLES(5)) dut_c (
        .int_osc(int_osc), .reset(reset), .bus(ifc)
    );

    always #5 int_osc = ~int_osc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Model: a running display is just a position k within a frame of fixed length.
    bit          run [3];
    int unsigned k   [3];
    bit [3:0]    c0  [3];
    bit [3:0]    c1  [3];

    function automatic int unsigned flen(input int i);
`ifdef SEG_MUX_BLANK_EN
        return 2 * DW[i] + 2 * BW[i];
`else
        return 2 * DW[i];
`endif
    endfunction

    function automatic int unsigned s1pos(input int i);
`ifdef SEG_MUX_BLANK_EN
        return DW[i] + BW[i];
`else
        return DW[i];
`endif
    endfunction

    function automatic logic [1:0] m_sw(input int i);
        if (!run[i]) return 2'b00;
        if (k[i] < DW[i]) return 2'b01;
        if (k[i] >= s1pos(i) && k[i] < s1pos(i) + DW[i]) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [3:0] m_ds(input int i);
        case (m_sw(i))
            2'b01:   return c0[i];
            2'b10:   return c1[i];
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic m_ft(input int i);
        return run[i] && (k[i] == flen(i) - 1);
    endfunction

    always @(posedge int_osc or negedge reset) begin
        for (int i = 0; i < 3; i++) begin
            int unsigned nk;
            nk = (k[i] + 1) % flen(i);
            if (!reset) begin
                run[i] <= 1'b0;
                k[i]   <= 0;
                c0[i]  <= 4'h0;
                c1[i]  <= 4'h0;
            end else if (!run[i]) begin
                if (en) begin
                    run[i] <= 1'b1;
                    k[i]   <= 0;
                    c0[i]  <= s0;
                end
            end else if (!en) begin
                run[i] <= 1'b0;
                k[i]   <= 0;
            end else begin
                k[i] <= nk;
                if (nk == 0) c0[i] <= s0;
                if (nk == s1pos(i)) c1[i] <= s1;
            end
        end
    end

    always @(negedge int_osc) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("dut%0d.switch", i),     32'(sw[i]), 32'(m_sw(i)));
            chk($sformatf("dut%0d.digit_sel", i),  32'(ds[i]), 32'(m_ds(i)));
            chk($sformatf("dut%0d.frame_tick", i), 32'(ft[i]), 32'(m_ft(i)));
        end
    end

    logic [23:0] rec_a, rec_b, rec_c;
    int          tk_a, tk_b, tk_c;
    int          cyc;

    initial begin
        int_osc = 1'b0;
        reset   = 1'b1;
        en      = 1'b0;
        s0      = 4'h3;
        s1      = 4'hA;
        rec_a   = '0;
        rec_b   = '0;
        rec_c   = '0;
        tk_a    = 0;
        tk_b    = 0;
        tk_c    = 0;
        #1 reset = 1'b0;

        repeat (2) @(negedge int_osc);
        chk("reset.switch", 32'(sw[0]), 32'h0);
        chk("reset.digit_sel", 32'(ds[0]), 32'h0);
        chk("reset.frame_tick", 32'(ft[0]), 32'h0);
        reset = 1'b1;
        @(negedge int_osc);
        chk("idle_en0.switch", 32'(sw[0]), 32'h0);
        en = 1'b1;

        // Steady scan, with s0 changed in the 2nd SHOW0 cycle
        for (int c = 0; c < 24; c++) begin
            @(negedge int_osc);
            if (c < 12) begin
                rec_a = {rec_a[21:0], sw[0]};
                rec_b = {rec_b[21:0], sw[1]};
                rec_c = {rec_c[21:0], sw[2]};
            end
            if (ft[0]) tk_a++;
            if (ft[1]) tk_b++;
            if (ft[2]) tk_c++;
            if (c == 1) s0 = 4'h7;
            if (c == 3) chk("hold_s0.digit_sel", 32'(ds[0]), 32'h3);
            if (c == S1A) chk("show1.digit_sel", 32'(ds[0]), 32'hA);
            if (c == LA - 2) chk("pre_tick.frame_tick", 32'(ft[0]), 32'h0);
            if (c == LA - 1) chk("tick.frame_tick", 32'(ft[0]), 32'h1);
            if (c == LA) chk("new_s0.digit_sel", 32'(ds[0]), 32'h7);
        end
        chk("seq_a.switch", 32'(rec_a), 32'(EXP_A));
        chk("seq_b.switch", 32'(rec_b), 32'(EXP_B));
        chk("seq_c.switch", 32'(rec_c), 32'(EXP_C));
        chk("ticks_a", 32'(tk_a), 32'(TK_A));
        chk("ticks_b", 32'(tk_b), 32'(TK_B));
        chk("ticks_c", 32'(tk_c), 32'(TK_C));

        // Drop en in the 3rd SHOW1 cycle
        cyc = 23;
        while ((cyc % LA) != S1A + 2) begin
            @(negedge int_osc);
            cyc++;
        end
        chk("drop_pre.switch", 32'(sw[0]), 32'h2);
        en = 1'b0;
        repeat (3) begin
            @(negedge int_osc);
            chk("drop.switch", 32'(sw[0]), 32'h0);
            chk("drop.frame_tick", 32'(ft[0]), 32'h0);
        end
        s0 = 4'h5;
        en = 1'b1;
        @(negedge int_osc);
        chk("reen.switch", 32'(sw[0]), 32'h1);
        chk("reen.digit_sel", 32'(ds[0]), 32'h5);

        // Asynchronous reset between edges mid-SHOW0
        #2 reset = 1'b0;
        #1;
        chk("areset.switch", 32'(sw[0]), 32'h0);
        chk("areset.digit_sel", 32'(ds[0]), 32'h0);
        chk("areset.switch_b", 32'(sw[1]), 32'h0);
        #1 reset = 1'b1;
        @(posedge int_osc);
        #1;
        chk("rel.switch", 32'(sw[0]), 32'h1);
        chk("rel.digit_sel", 32'(ds[0]), 32'h5);

        repeat (40) @(negedge int_osc);
        en = 1'b0;
        repeat (4) @(negedge int_osc);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seg_mux_ctrl.md
SEG_MUX_CTRL -- requirements
Module: seg_mux_ctrl

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 10_000, meaning int_osc cycles each digit is driven (legal range 1..2^24-1).
REQ-002 SHALL have parameter BLANK_CYCLES, default 100, meaning int_osc cycles both digits are off between digits (legal range 1..2^24-1).
REQ-003 SHALL have port int_osc, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1, scan enable; 0 forces the display dark.
REQ-006 SHALL have port s0, input, 4, hex value for digit 0.
REQ-007 SHALL have port s1, input, 4, hex value for digit 1.
REQ-008 SHALL have port digit_sel, output, 4, nibble routed to the shared seven-segment decoder.
REQ-009 SHALL have port switch, output, 2, one-hot active-high digit drive: 01 = digit 0, 10 = digit 1, 00 = off.
REQ-010 SHALL have port frame_tick, output, 1, one-cycle pulse at the end of each full two-digit frame.

Function
REQ-011 SHALL implement the FSM states IDLE, SHOW0, BLANK0, SHOW1 and BLANK1.
REQ-012 SHALL, from IDLE with en=1, enter SHOW0 on the next edge; with en=0 it SHALL remain in IDLE.
REQ-013 SHALL use one 24-bit dwell counter, cleared on every state entry and incremented each cycle.
REQ-014 SHALL leave SHOWx when the counter equals DWELL_CYCLES-1 and BLANKx when it equals BLANK_CYCLES-1, so every state lasts exactly its parameter in cycles.
REQ-015 SHALL follow the transitions SHOW0->BLANK0->SHOW1->BLANK1->SHOW0, and SHALL loop continuously while en=1.
REQ-016 SHALL capture s0 into an internal register on the edge entering SHOW0, and s1 on the edge entering SHOW1; input changes during a dwell SHALL NOT affect digit_sel until the next entry.
REQ-017 SHALL drive switch=01 and digit_sel=captured s0 in SHOW0, and switch=10 and digit_sel=captured s1 in SHOW1.
REQ-018 SHALL drive switch=00 and digit_sel=4'h0 in IDLE, BLANK0 and BLANK1.
REQ-019 SHALL register all outputs, so they change only on int_osc edges and never both switch bits are 1.
REQ-020 SHALL assert frame_tick for exactly the last cycle of BLANK1 (the cycle before re-entering SHOW0).
REQ-021 SHALL, when en is sampled 0 in any non-IDLE state, go to IDLE on that edge, with switch=00 the following cycle and the counter cleared; no frame_tick SHALL be emitted.
REQ-022 SHALL, when en is re-asserted, always restart at SHOW0 with a fresh s0 capture.
REQ-023 SHALL, with DWELL_CYCLES=1 or BLANK_CYCLES=1, hold the corresponding state for exactly one cycle with no counter wrap.

Reset
REQ-024 SHALL, on reset=0, asynchronously force state IDLE, counter 0, captured digits 4'h0, switch=00, digit_sel=4'h0 and frame_tick=0.
REQ-025 SHALL, after reset release, enter SHOW0 on the first int_osc edge with en=1; reset asserted mid-dwell SHALL blank the display immediately, without waiting for a clock edge.

Configuration
REQ-026 SHALL, when macro SEG_MUX_BLANK_EN is defined, include BLANK0 and BLANK1 as specified.
REQ-027 SHALL, when SEG_MUX_BLANK_EN is undefined, omit both blank states (SHOW0->SHOW1->SHOW0), ignore BLANK_CYCLES, and assert frame_tick on the last cycle of SHOW1; all other requirements still apply.

Verification
REQ-028 Bench SHALL cover: DWELL=4, BLANK=2, blank enabled, en=1, s0=3, s1=A -> switch sequence 01x4, 00x2, 10x4, 00x2, repeating; digit_sel 3 then A; frame_tick once per 12 cycles.
REQ-029 Bench SHALL cover: s0 changed 3->7 in the 2nd cycle of SHOW0 -> digit_sel stays 3 for the rest of that dwell and shows 7 at the next SHOW0.
REQ-030 Bench SHALL cover: en dropped in the 3rd cycle of SHOW1 -> switch=00 the next cycle and no frame_tick; on en re-asserted -> SHOW0 entered next edge with switch=01.
REQ-031 Bench SHALL cover: reset pulsed low asynchronously between edges mid-SHOW0 -> switch=00 and digit_sel=0 immediately; on release with en=1 -> SHOW0 on the first edge.
REQ-032 Bench SHALL cover: DWELL=1, BLANK=1 -> states advance every cycle, switch 01,00,10,00, frame_tick every 4th cycle.
REQ-033 Bench SHALL cover: blank disabled, DWELL=3 -> switch 01x3, 10x3, repeating, no 00 cycles, frame_tick every 6 cycles; switch=11 is never observed in any run.
